// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: layer-side sequencer for a bank of fully-connected neurons.
// Accepts PREVIOUS_LAYER_HEIGHT activations per vector and broadcasts each
// one to every neuron with its weight address. It then issues one bias step
// and serializes the LAYER_HEIGHT neuron outputs downstream. The last output
// handshake clears the neuron accumulators.
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   valid_i/ready_o/data_i    upstream activation handshake
//   neuron_data_o, mem_addr_o broadcast word and weight/bias address
//   sum_en_o, add_bias_o      neuron accumulate / bias-add strobes
//   clear_o                   neuron accumulator clear strobe
//   neuron_data_i             packed neuron outputs, neuron k at [k*W +: W]
//   valid_o/ready_i/data_o    downstream serialized output handshake
module fc_layer_ctrl #(
  parameter int WORD_SIZE             = 16,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int LAYER_HEIGHT          = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic [WORD_SIZE-1:0]                     data_i,
  output logic [WORD_SIZE-1:0]                     neuron_data_o,
  output logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0] mem_addr_o,
  output logic                                     sum_en_o,
  output logic                                     add_bias_o,
  output logic                                     clear_o,
  input  logic [LAYER_HEIGHT*WORD_SIZE-1:0]        neuron_data_i,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic [WORD_SIZE-1:0]                     data_o
);

  localparam int AW = $clog2(PREVIOUS_LAYER_HEIGHT+1);
  localparam int OW = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
  localparam logic [AW-1:0] LAST_IN   = AW'(PREVIOUS_LAYER_HEIGHT-1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(PREVIOUS_LAYER_HEIGHT);
  localparam logic [OW-1:0] LAST_OUT  = OW'(LAYER_HEIGHT-1);

  typedef enum logic [1:0] {eREADY, eBIAS, eDONE} state_t;

  state_t        state;
  logic [AW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= eREADY;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        eREADY: begin
          if (valid_i) begin
            if (in_cnt == LAST_IN) begin
              state  <= eBIAS;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        eBIAS: begin
          state   <= eDONE;
          out_cnt <= '0;
        end
        eDONE: begin
          if (ready_i) begin
            if (out_cnt == LAST_OUT) begin
              state   <= eREADY;
              out_cnt <= '0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= eREADY;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
      endcase
    end
  end

  // Strobes decode from the registered state; gating with reset_n_i holds
  // every strobe low for the whole reset window, not just after the edge.
  always_comb begin
    ready_o       = 1'b0;
    valid_o       = 1'b0;
    sum_en_o      = 1'b0;
    add_bias_o    = 1'b0;
    clear_o       = 1'b0;
    mem_addr_o    = '0;
    neuron_data_o = '0;
    data_o        = '0;
    if (reset_n_i) begin
      case (state)
        eREADY: begin
          ready_o       = 1'b1;
          mem_addr_o    = in_cnt;
          neuron_data_o = data_i;
          sum_en_o      = valid_i;
        end
        eBIAS: begin
          mem_addr_o = BIAS_ADDR;
          add_bias_o = 1'b1;
          sum_en_o   = 1'b1;
        end
        eDONE: begin
          valid_o = 1'b1;
          clear_o = ready_i && (out_cnt == LAST_OUT);
          for (int unsigned k = 0; k < LAYER_HEIGHT; k++) begin
            if (OW'(k) == out_cnt) data_o = neuron_data_i[k*WORD_SIZE +: WORD_SIZE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
module tb_fc_layer_ctrl;

  localparam int W  = 16;
  localparam int P  = 4;
  localparam int L  = 4;
  localparam int AW = $clog2(P+1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_i;
  logic [W-1:0]  neuron_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          sum_en_o;
  logic          add_bias_o;
  logic          clear_o;
  logic [L*W-1:0] neuron_data_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;

  fc_layer_ctrl #(
    .WORD_SIZE(W),
    .PREVIOUS_LAYER_HEIGHT(P),
    .LAYER_HEIGHT(L)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .neuron_data_o(neuron_data_o),
    .mem_addr_o(mem_addr_o),
    .sum_en_o(sum_en_o),
    .add_bias_o(add_bias_o),
    .clear_o(clear_o),
    .neuron_data_i(neuron_data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  logic [W-1:0] bank [L];
  always_comb begin
    neuron_data_i = '0;
    for (int k = 0; k < L; k++) neuron_data_i[k*W +: W] = bank[k];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a vector is P accepted words, one bias beat, then L
  // output words. Position within the vector is tracked only as counts.
  int  words_in  = 0;
  int  words_out = 0;
  bit  bias_seen = 0;
  bit  rand_bank = 0;
  bit  last_acc  = 0;

  task automatic model_reset();
    words_in  = 0;
    words_out = 0;
    bias_seen = 0;
  endtask

  // Enter at posedge+1: drive, check at negedge, advance model after posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    bit taking, biasing, emitting;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    taking   = (words_in < P);
    biasing  = !taking && !bias_seen;
    emitting = !taking && bias_seen;
    @(negedge clk_i);
    check("ready_o",  ready_o, taking);
    check("valid_o",  valid_o, emitting);
    check("add_bias", add_bias_o, biasing);
    check("sum_en",   sum_en_o, (taking && v) || biasing);
    check("clear_o",  clear_o, emitting && r && (words_out == L-1));
    if (taking) begin
      check("mem_addr", mem_addr_o, words_in);
      if (v) check("nd_out", neuron_data_o, d);
    end
    if (biasing) begin
      check("bias_addr", mem_addr_o, P);
      check("bias_data", neuron_data_o, 0);
    end
    if (emitting) check("data_o", data_o, bank[words_out]);
    @(posedge clk_i);
    #1;
    last_acc = taking && v;
    if (taking) begin
      if (v) words_in++;
    end else if (biasing) begin
      bias_seen = 1;
    end else if (r) begin
      words_out++;
      if (words_out == L) begin
        model_reset();
        if (rand_bank) for (int k = 0; k < L; k++) bank[k] = W'($urandom);
      end
    end
  endtask

  task automatic run_vector(input int base);
    for (int i = 0; i < P; i++) step(1'b1, W'(base + i), 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b1);
  endtask

  logic [W-1:0] cur_d;
  logic         cur_v;

  initial begin
    for (int k = 0; k < L; k++) bank[k] = W'(10 * (k + 1));
    reset_n_i = 1'b0;
    valid_i   = 1'b1;
    data_i    = 16'd7;
    ready_i   = 1'b1;

    // Reset: strobes low with valid_i high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_ready", ready_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_sum",   sum_en_o, 0);
      check("rst_bias",  add_bias_o, 0);
      check("rst_clear", clear_o, 0);
      check("rst_addr",  mem_addr_o, 0);
      check("rst_data",  data_o, 0);
    end
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;

    // Back-to-back vector 1..4
    run_vector(1);

    // Gapped input
    for (int i = 0; i < P; i++) begin
      step(1'b1, W'(100 + i), 1'b1);
      step(1'b0, W'(555), 1'b1);
    end
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b1);

    // Backpressure at output index 2
    for (int i = 0; i < P; i++) step(1'b1, W'(200 + i), 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // valid_i held through bias/output with 99, then accepted at address 0
    for (int i = 0; i < P; i++) step(1'b1, W'(5 + i), 1'b1);
    for (int i = 0; i < 1 + L; i++) step(1'b1, W'(99), 1'b1);
    step(1'b1, W'(99), 1'b1);
    for (int i = 1; i < P; i++) step(1'b1, W'(60 + i), 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset while emitting output index 1
    for (int i = 0; i < P; i++) step(1'b1, W'(300 + i), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("pre_rst_valid", valid_o, 1);
    #1 reset_n_i = 1'b0;
    #1;
    check("async_valid", valid_o, 0);
    check("async_clear", clear_o, 0);
    check("async_addr",  mem_addr_o, 0);
    check("async_data",  data_o, 0);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    run_vector(1);

    // Randomized traffic with per-vector random neuron outputs
    rand_bank = 1;
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!cur_v || last_acc) cur_d = W'($urandom);
      cur_v = ($urandom_range(0, 3) != 0);
      step(cur_v, cur_d, ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer_ctrl.md
Name: fc_layer_ctrl

Overview:
Layer-side sequencer for a bank of fully-connected neurons. It accepts the previous layer's activations one word per handshake and broadcasts each word to all neurons with the matching weight address and sum enable. It then issues the bias step and serializes the neurons' ReLU outputs to the next layer over a valid/ready handshake. Finally it clears the neuron accumulators for the next input vector.

Parameters:
WORD_SIZE, 16, width of every data word
PREVIOUS_LAYER_HEIGHT, 4, input words per vector; also the weight count per neuron (bias stored at address PREVIOUS_LAYER_HEIGHT)
LAYER_HEIGHT, 4, number of neurons driven; also the output words per vector

Ports:
clk_i  input  1  clock; all state updates on the rising edge
reset_n_i  input  1  asynchronous, active-low reset
valid_i  input  1  previous layer has a word on data_i
ready_o  output  1  controller accepts data_i this cycle
data_i  input  WORD_SIZE  activation from the previous layer
neuron_data_o  output  WORD_SIZE  broadcast to every neuron's data input
mem_addr_o  output  $clog2(PREVIOUS_LAYER_HEIGHT+1)  weight/bias address to every neuron
sum_en_o  output  1  neurons accumulate on this edge
add_bias_o  output  1  neurons add the bias instead of the product
clear_o  output  1  neurons zero their accumulator on this edge
neuron_data_i  input  LAYER_HEIGHT*WORD_SIZE  neuron outputs; neuron k occupies bits [k*WORD_SIZE +: WORD_SIZE]
valid_o  output  1  data_o holds a valid output word
ready_i  input  1  next layer accepts data_o
data_o  output  WORD_SIZE  serialized neuron output

Behaviour:
- The design has one clock, clk_i. Reset is reset_n_i: asynchronous and active-low. The layer top also ties each neuron's reset_i to ~reset_n_i.
- While reset_n_i is low:
  - state = eREADY; in_cnt = 0; out_cnt = 0.
  - ready_o, valid_o, sum_en_o, add_bias_o and clear_o are all 0.
  - mem_addr_o = 0; data_o = 0.
- States:
  - eREADY: accepts inputs.
  - eBIAS: lasts exactly one cycle.
  - eDONE: serializes the neuron outputs.
- eREADY behaviour:
  - ready_o = 1 and mem_addr_o = in_cnt.
  - neuron_data_o = data_i, combinationally.
  - sum_en_o = valid_i (it is 1 only on a handshake).
  - Each handshake increments in_cnt.
  - The handshake with in_cnt == PREVIOUS_LAYER_HEIGHT-1 moves the block to eBIAS and resets in_cnt to 0.
  - When valid_i = 0, nothing changes.
- eBIAS behaviour:
  - ready_o = 0; mem_addr_o = PREVIOUS_LAYER_HEIGHT.
  - add_bias_o = 1 and sum_en_o = 1.
  - neuron_data_o = 0.
  - Next state is eDONE with out_cnt = 0.
- eDONE behaviour:
  - ready_o = 0; sum_en_o = 0; valid_o = 1.
  - data_o = neuron_data_i slice [out_cnt], driven combinationally. Neuron outputs are registered, so data_o is stable while the handshake is held off.
  - Each valid_o && ready_i handshake increments out_cnt.
  - If ready_i = 0, out_cnt and data_o hold and clear_o stays 0.
  - The handshake with out_cnt == LAYER_HEIGHT-1 asserts clear_o for that cycle only. Next state is eREADY with out_cnt = 0.
- Outside eDONE, valid_o = 0. Outside eBIAS, add_bias_o = 0.
- clear_o never coincides with sum_en_o.
- Throughput with valid_i and ready_i held high: PREVIOUS_LAYER_HEIGHT + 1 + LAYER_HEIGHT cycles per vector. There are no idle cycles between vectors.
- valid_i while ready_o = 0:
  - No effect; the word is not consumed.
  - The previous layer must hold data_i stable until the handshake.
- Counter widths:
  - in_cnt uses the mem_addr_o width.
  - out_cnt uses max(1, $clog2(LAYER_HEIGHT)).
  - Neither counter ever wraps past its limit.
- PREVIOUS_LAYER_HEIGHT = 1 and LAYER_HEIGHT = 1 must both work. With LAYER_HEIGHT = 1, the first output handshake asserts clear_o.
- Reset asserted mid-operation, in any state: the asynchronous return to the reset values above. No clear_o pulse is issued; the neurons are cleared by their own reset.

Test Plan:
1. Reset: hold reset_n_i low for 3 cycles with valid_i = 1 → ready_o, valid_o, sum_en_o, add_bias_o and clear_o are all 0, mem_addr_o = 0. After release, ready_o = 1 on the next cycle.
2. Back-to-back (PREVIOUS_LAYER_HEIGHT = 4, LAYER_HEIGHT = 4, ready_i = 1), inputs 1, 2, 3, 4 on cycles 0–3:
   - sum_en_o = 1 with mem_addr_o = 0, 1, 2, 3 and neuron_data_o = 1, 2, 3, 4.
   - Cycle 4: add_bias_o = 1, mem_addr_o = 4.
   - Cycles 5–8: valid_o = 1, with data_o = neuron slices 0, 1, 2, 3 (driven as 10, 20, 30, 40).
   - clear_o = 1 only on cycle 8; ready_o = 1 on cycle 9.
3. Gapped input: valid_i alternates 1/0 → mem_addr_o advances only on handshakes. sum_en_o = 0 on the gap cycles. eBIAS occurs one cycle after the 4th handshake.
4. Backpressure: ready_i = 0 for 3 cycles at out_cnt = 2 → data_o stays 30 and valid_o stays 1, with no clear_o. After ready_i = 1, the outputs 30 and 40 complete with clear_o on the 40 beat.
5. valid_i held at 1 through eBIAS and eDONE with data_i = 99 → ready_o = 0 and sum_en_o = 0 throughout. 99 is accepted at mem_addr_o = 0 on the first eREADY cycle.
6. Reset asserted at out_cnt = 1 in eDONE → valid_o drops immediately (asynchronously). After release: eREADY, mem_addr_o = 0, and a fresh vector completes as in test 2.
